// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and parity modes.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } rx_state_t;

    // Expected parity bit for a word whose XOR-reduction is data_xor.
    function automatic logic parity_bit(input logic data_xor, input int mode);
        return (mode == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, reset to a chosen level.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: sequential state is written with non-blocking assignments so both flops
    // sample their inputs from the same edge; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: majority-voted bits, optional parity, break detection,
// single-word output buffer with valid/ready handshake and one-clk error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVS_FACTOR = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = PAR_NONE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick_16x,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err
);

    localparam int CW = $clog2(OVS_FACTOR);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_LAST   = CW'(OVS_FACTOR - 1);
    localparam logic [CW-1:0] VOTE_FIRST = CW'(OVS_FACTOR / 2 - 1);
    localparam logic [CW-1:0] VOTE_LAST  = CW'(OVS_FACTOR / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);

    if (OVS_FACTOR < 8 || (OVS_FACTOR & (OVS_FACTOR - 1)) != 0) begin : g_bad_ovs
        $error("uart_rx: OVS_FACTOR must be a power of 2 and at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
        $error("uart_rx: DATA_BITS must be in 5..9");
    end

    logic                 rx_s;
    rx_state_t            state_q;
    logic [CW-1:0]        cnt_q;
    logic [1:0]           ones_q;
    logic [1:0]           ones_d;
    logic [BW-1:0]        bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_err_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 parity_err_q;
    logic                 overrun_err_q;

    logic in_window;
    logic voted;
    logic exp_par;
    logic handshake;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    // Samples at the three centre ticks are accumulated; the vote is final on the
    // last of them, so the bit decision uses the running count plus the current sample.
    assign in_window = (cnt_q >= VOTE_FIRST) && (cnt_q <= VOTE_LAST);
    assign ones_d    = ones_q + {1'b0, rx_s};
    assign voted     = ones_d[1];
    assign exp_par   = parity_bit(^shift_q, PARITY);
    assign handshake = rx_valid_q && rx_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            ones_q        <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            par_err_q     <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            parity_err_q  <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            frame_err_q   <= 1'b0;
            parity_err_q  <= 1'b0;
            overrun_err_q <= 1'b0;
            if (handshake) begin
                rx_valid_q <= 1'b0;
            end

            if (tick_16x) begin
                cnt_q <= cnt_q + 1'b1;
                if (in_window) begin
                    ones_q <= ones_d;
                end
                if (cnt_q == CNT_LAST) begin
                    ones_q <= '0;
                end

                case (state_q)
                    S_IDLE: begin
                        cnt_q     <= '0;
                        ones_q    <= '0;
                        par_err_q <= 1'b0;
                        if (!rx_s) begin
                            state_q <= S_START;
                        end
                    end
                    S_START: begin
                        if (cnt_q == VOTE_LAST && voted) begin
                            state_q <= S_IDLE;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q   <= S_DATA;
                            bit_idx_q <= '0;
                        end
                    end
                    S_DATA: begin
                        if (cnt_q == VOTE_LAST) begin
                            shift_q <= {voted, shift_q[DATA_BITS-1:1]};
                        end
                        if (cnt_q == CNT_LAST) begin
                            if (bit_idx_q == BIT_LAST) begin
                                state_q <= (PARITY == PAR_NONE) ? S_STOP : S_PARITY;
                            end else begin
                                bit_idx_q <= bit_idx_q + 1'b1;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (cnt_q == VOTE_LAST) begin
                            par_err_q <= (voted != exp_par);
                        end
                        if (cnt_q == CNT_LAST) begin
                            state_q <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        // Decide mid stop bit so a back-to-back start edge is not missed.
                        if (cnt_q == VOTE_LAST) begin
                            if (!voted) begin
                                frame_err_q <= 1'b1;
                                state_q     <= S_BREAK;
                            end else begin
                                state_q <= S_IDLE;
                                if (par_err_q) begin
                                    parity_err_q <= 1'b1;
                                end else if (rx_valid_q && !rx_ready) begin
                                    overrun_err_q <= 1'b1;
                                end else begin
                                    rx_data_q  <= shift_q;
                                    rx_valid_q <= 1'b1;
                                end
                            end
                        end
                    end
                    S_BREAK: begin
                        if (rx_s) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign parity_err  = parity_err_q;
    assign overrun_err = overrun_err_q;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OVS_FACTOR, default 16, giving tick_16x pulses per bit; it SHALL be a power of 2 and at least 8.
REQ-002 SHALL have parameter DATA_BITS, default 8, giving data bits per frame (5..9).
REQ-003 SHALL have parameter PARITY, default 0, where 0 = none, 1 = odd, 2 = even.
REQ-004 clk  input  1  sole clock; all logic rising-edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 tick_16x  input  1  one-clk oversample strobe from baud generator.
REQ-007 rx  input  1  asynchronous serial line, idle high.
REQ-008 rx_data  output  DATA_BITS  received word, LSB first on line.
REQ-009 rx_valid  output  1  rx_data holds an unconsumed word.
REQ-010 rx_ready  input  1  consumer accepts the word when rx_valid && rx_ready.
REQ-011 frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-012 parity_err  output  1  one-clk pulse: parity mismatch.
REQ-013 overrun_err  output  1  one-clk pulse: word completed while rx_valid still set.

Function
REQ-014 rx SHALL pass through a 2-flop synchroniser reset to 1; all decisions use the synchronised value.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BREAK; the sample counter and FSM advance only on tick_16x.
REQ-016 IDLE -> START on the first tick_16x where synchronised rx = 0; sample counter cleared.
REQ-017 Each bit value SHALL be the majority vote of samples OVS_FACTOR/2-1, OVS_FACTOR/2, OVS_FACTOR/2+1 within the bit.
REQ-018 START: a voted 1 (false start) SHALL return to IDLE with no output; a voted 0 SHALL enter DATA after OVS_FACTOR ticks.
REQ-019 DATA SHALL shift DATA_BITS voted bits LSB first, then go to PARITY if PARITY != 0, else STOP.
REQ-020 PARITY SHALL compare the voted bit with odd or even parity of the data; a mismatch is recorded for the STOP decision.
REQ-021 STOP SHALL decide at the stop bit's vote point, not at bit end, and return to IDLE on a voted 1.
REQ-022 Voted stop 1 with no parity error: rx_data loads the word and rx_valid is set on the next clk, unless overrun applies.
REQ-023 Voted stop 1 with a parity error: parity_err pulses, rx_data and rx_valid are unchanged, and the word is discarded.
REQ-024 Voted stop 0: frame_err pulses, the word is discarded, and the FSM enters BREAK.
REQ-025 BREAK SHALL remain until the synchronised rx is 1 on a tick_16x, then go to IDLE.
REQ-026 Overrun: if rx_valid = 1 and rx_ready = 0 at completion, overrun_err pulses and the old word is kept; the new word is dropped.
REQ-027 If rx_valid && rx_ready coincides with completion, the new word loads and rx_valid stays 1 with no overrun.
REQ-028 rx_valid SHALL clear on the clk after a handshake; rx_data SHALL stay stable while rx_valid = 1.
REQ-029 Error pulses are mutually exclusive per frame and last exactly one clk.

Reset
REQ-030 On reset = 0: FSM = IDLE, counters 0, synchroniser 1, rx_data 0, rx_valid 0, all error outputs 0.
REQ-031 Reset mid-frame SHALL abandon the frame; after release, reception resumes only on a new falling edge.

Structure
REQ-032 The shared package uart_pkg SHALL hold the FSM state enum and the PARITY encodings (PAR_NONE, PAR_ODD, PAR_EVEN).
REQ-033 The 2-flop synchroniser SHALL be a sub-module, sync_2ff.
REQ-034 The block SHALL be driven by the existing baud generator's tick_16x output, with the generator at the same OVS_FACTOR.

Verification
REQ-035 8N1, 115200 baud, 100 MHz, byte 0xA5 -> rx_valid = 1, rx_data = 0xA5, no error pulses.
REQ-036 Low glitch of 4 ticks on an idle line -> FSM returns to IDLE, rx_valid stays 0.
REQ-037 PARITY = 2, byte 0x07 sent with the parity bit 0 -> parity_err pulse, rx_valid unchanged.
REQ-038 Frame 0x3C with stop = 0, then line held low for 20 bits -> one frame_err pulse, no reception until rx returns high; next byte 0x55 received correctly.
REQ-039 rx_ready = 0, bytes 0x11 then 0x22 sent -> overrun_err pulse, rx_data = 0x11; with rx_ready = 1, rx_valid clears the next clk.
REQ-040 reset asserted during data bit 3 of 0xFF, released, then 0x81 sent -> only 0x81 delivered.
